// File: rtl/digit_scanner_pkg.sv
// rtl/digit_scanner_pkg.sv - shared constants and types for the digit scanner
package digit_scanner_pkg;

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_SHOW  = 1'b1;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    BLANK = ST_BLANK,
    SHOW  = ST_SHOW
  } scan_state_t;

endpackage

// File: rtl/refresh_timer.sv
// rtl/refresh_timer.sv - per-digit slot counter with end-of-slot flag
module refresh_timer #(
  parameter int DIV = 1000,
  parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] slot_cnt,
  output logic          slot_end
);

  assign slot_end = (slot_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - time-multiplexed BCD digit scanner with tear-free double buffering
module digit_scanner
  import digit_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
  output logic                        load_ready,
  input  logic [NUM_DIGITS-1:0]       digit_mask,
  output logic [BCD_W-1:0]            datain,
  output logic                        good,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic                        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0] slot_cnt;
  logic          slot_end;

  refresh_timer #(
    .DIV (REFRESH_DIV),
    .CW  (CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .slot_cnt (slot_cnt),
    .slot_end (slot_end)
  );

  logic [IW-1:0]                     idx, idx_nxt;
  scan_state_t                       state, state_nxt;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]  disp_q, pend_q, disp_nxt;
  logic [CW-1:0]                     cnt_nxt;
  logic                              boundary, accept, ready_nxt;
  logic [BCD_W-1:0]                  dig_nxt;
  logic                              mask_nxt;
  logic [NUM_DIGITS-1:0]             anode_nxt;
  logic                              good_nxt, frame_nxt;

  // Everything below is computed for the *next* cycle, so the registered
  // outputs line up with the slot counter and index they describe.
  always_comb begin
    cnt_nxt   = slot_cnt + 1'b1;
    idx_nxt   = idx;
    state_nxt = SHOW;
    disp_nxt  = disp_q;
    anode_nxt = '0;
    good_nxt  = 1'b0;
    ready_nxt = load_ready;

    boundary = slot_end && (idx == IW'(NUM_DIGITS - 1));
    accept   = load && load_ready;

    if (slot_end) begin
      cnt_nxt = '0;
      idx_nxt = boundary ? '0 : idx + 1'b1;
    end

    if ((BLANK_CYCLES > 0) && (32'(cnt_nxt) < 32'(BLANK_CYCLES))) begin
      state_nxt = BLANK;
    end

    // Pending only drains at the frame boundary, so a frame is never mixed.
    if (boundary && !load_ready) begin
      disp_nxt  = pend_q;
      ready_nxt = 1'b1;
    end else if (accept) begin
      ready_nxt = 1'b0;
    end

    dig_nxt  = disp_nxt[idx_nxt];
    mask_nxt = digit_mask[idx_nxt];

    if (state_nxt == SHOW) begin
      anode_nxt[idx_nxt] = mask_nxt;
      good_nxt           = mask_nxt && (dig_nxt <= BCD_MAX);
    end

    frame_nxt = (cnt_nxt == CW'(REFRESH_DIV - 1)) && (idx_nxt == IW'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q     <= '0;
      pend_q     <= '0;
      load_ready <= 1'b1;
    end else begin
      disp_q     <= disp_nxt;
      load_ready <= ready_nxt;
      if (accept) begin
        pend_q <= load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      datain     <= '0;
      good       <= 1'b0;
      anode      <= '0;
      frame_done <= 1'b0;
    end else begin
      datain     <= dig_nxt;
      good       <= good_nxt;
      anode      <= anode_nxt;
      frame_done <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_digit_scanner.sv
// tb/tb_digit_scanner.sv - randomized and directed bench for digit_scanner against a frame-level model
module tb_digit_scanner;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   load_data = '0;
  logic          load_ready;
  logic [3:0]    digit_mask = 4'hF;
  logic [3:0]    datain;
  logic          good;
  logic [3:0]    anode;
  logic          frame_done;

  digit_scanner #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .load_ready (load_ready),
    .digit_mask (digit_mask),
    .datain     (datain),
    .good       (good),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          t;
  logic [15:0] disp_m;
  logic [15:0] pend_v;
  int          pend_f;
  logic [3:0]  mask_prev;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t         = 0;
    disp_m    = '0;
    pend_v    = '0;
    pend_f    = -1;
    mask_prev = 4'hF;
  endtask

  // One cycle: check outputs of cycle t, then drive inputs sampled at its closing edge.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] m);
    int         slot, dig;
    logic       dark;
    logic [3:0] val;
    @(negedge clk);
    if (pend_f >= 0 && pend_f <= t / FRAME) begin
      disp_m = pend_v;
      pend_f = -1;
    end
    slot = t % DIV;
    dig  = (t / DIV) % N;
    dark = slot < BLK;
    val  = 4'((disp_m >> (4 * dig)) & 16'hF);
    chk("datain", 16'(datain), 16'(val));
    chk("anode", 16'(anode), dark ? 16'h0 : 16'(mask_prev[dig]) << dig);
    chk("good", 16'(good), 16'(!dark && mask_prev[dig] && val <= 4'd9));
    chk("frame_done", 16'(frame_done), 16'((t % FRAME) == FRAME - 1));
    chk("load_ready", 16'(load_ready), 16'(pend_f < 0));
    load       = ld;
    load_data  = d;
    digit_mask = m;
    if (ld && pend_f < 0) begin
      pend_v = d;
      pend_f = (t + 1) / FRAME + 1;
    end
    mask_prev = m;
    t++;
  endtask

  task automatic run_until(input int stop_t, input logic [3:0] m);
    while (t < stop_t) step(1'b0, 16'h0, m);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    chk("rst_datain", 16'(datain), 16'h0);
    chk("rst_good", 16'(good), 16'h0);
    chk("rst_anode", 16'(anode), 16'h0);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    chk("rst_load_ready", 16'(load_ready), 16'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    step(1'b1, 16'h1234, 4'hF);
    run_until(2 * FRAME + 2 * DIV + 3, 4'hF);
    step(1'b1, 16'h5678, 4'hF);
    run_until(90, 4'hF);
    step(1'b1, 16'h9ABC, 4'hF);
    run_until(130, 4'hF);

    step(1'b1, 16'h45C7, 4'h7);
    run_until(6 * FRAME - 1, 4'h7);

    step(1'b1, 16'h9876, 4'hF);
    run_until(8 * FRAME + 4, 4'hF);

    async_reset();
    step(1'b1, 16'h0909, 4'hF);
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 15) == 0), 16'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
    end

    async_reset();
    run_until(40, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
